// File: rtl/mem_stage_pkg.sv
// Shared types and codes for the MEM stage: EX->MEM bus layout, load-extend ops, write-back selects.
// The same WB_* codes are used by EX and WB.
package mem_stage_pkg;

  localparam int DATA_W              = 32;
  localparam int EX_TO_MEM_BUS_WIDTH = 107;
  localparam int MEM_TO_WB_BUS_WIDTH = 38;
  localparam int MEM_TO_ID_BUS_WIDTH = 40;

  typedef enum logic [2:0] {
    MEM_EXT_LB  = 3'd0,
    MEM_EXT_LBU = 3'd1,
    MEM_EXT_LH  = 3'd2,
    MEM_EXT_LHU = 3'd3,
    MEM_EXT_LW  = 3'd4
  } mem_ext_op_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_EXT = 2'd1,
    WB_PC4 = 2'd2,
    WB_MEM = 2'd3
  } wb_sel_e;

  // Field order matches the packed EX->MEM bus, MSB first.
  typedef struct packed {
    logic [2:0]        mem_ext_op;
    logic              rf_we;
    logic [1:0]        rf_wsel;
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] ext;
    logic [4:0]        wb_reg;
    logic [DATA_W-1:0] alu_c;
  } ex_to_mem_t;

  function automatic logic ld_misaligned(input logic [2:0] op, input logic [1:0] offset);
    case (op)
      MEM_EXT_LH, MEM_EXT_LHU: return offset[0];
      MEM_EXT_LW:              return (offset != 2'b00);
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshake and data buses around the MEM stage: EX->MEM, MEM->WB, MEM->ID bypass/hazard, DRAM read data.
// slave is the MEM stage's view; master is the surrounding pipeline's view.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [EX_TO_MEM_BUS_WIDTH-1:0] ex_to_mem_bus;
  logic                           ex_to_mem_valid;
  logic                           wb_allow_in;
  logic [DATA_W-1:0]              dram_rdout;
  logic                           mem_allow_in;
  logic                           mem_to_wb_valid;
  logic [MEM_TO_WB_BUS_WIDTH-1:0] mem_to_wb_bus;
  logic [MEM_TO_ID_BUS_WIDTH-1:0] mem_to_id_bus;
  logic                           mem_exc;

  modport slave (
    input  ex_to_mem_bus, ex_to_mem_valid, wb_allow_in, dram_rdout,
    output mem_allow_in, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus, mem_exc
  );

  modport master (
    output ex_to_mem_bus, ex_to_mem_valid, wb_allow_in, dram_rdout,
    input  mem_allow_in, mem_to_wb_valid, mem_to_wb_bus, mem_to_id_bus, mem_exc
  );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Combinational load extender: picks byte/half/word at the given offset and sign- or zero-extends it.
// Misaligned halves/words still return data from the aligned word; misaligned_o only flags them.
module mem_stage_load_ext
  import mem_stage_pkg::*;
(
  input  logic [2:0]        op_i,
  input  logic [1:0]        offset_i,
  input  logic [DATA_W-1:0] word_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misaligned_o
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  assign byte_s = 8'(word_i >> {offset_i, 3'b000});
  assign half_s = offset_i[1] ? word_i[31:16] : word_i[15:0];

  always_comb begin
    data_o = word_i;
    case (op_i)
      MEM_EXT_LB:  data_o = DATA_W'(byte_s);
      MEM_EXT_LBU: data_o = DATA_W'($unsigned(byte_s));
      MEM_EXT_LH:  data_o = DATA_W'(half_s);
      MEM_EXT_LHU: data_o = DATA_W'($unsigned(half_s));
      default:     data_o = word_i;
    endcase
  end

  assign misaligned_o = ld_misaligned(op_i, offset_i);

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the RV32I pipeline: holds one instruction, waits LOAD_LAT cycles for DRAM on loads,
// selects the write-back value. Define MEM_MISALIGN_EXC_EN to flag misaligned loads and drop their write.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

`ifdef MEM_MISALIGN_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  localparam logic [2:0] LAT = 3'(LOAD_LAT);

  ex_to_mem_t        mem_regs_q;
  logic              mem_valid_q, mem_valid_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic              ld_held_q, ld_held_d;
  logic [DATA_W-1:0] ld_word_q;

  logic              is_ld, lat_done, mem_ready_go, mem_allow_in;
  logic              accept, capture, mem_to_wb_valid, load_busy;
  logic              misaligned, ld_fault, rf_we;
  logic [DATA_W-1:0] ld_src, ld_data, rf_wdata;

  assign is_ld           = (mem_regs_q.rf_wsel == WB_MEM);
  assign lat_done        = (lat_cnt_q == LAT);
  assign mem_ready_go    = !is_ld || lat_done;
  assign mem_allow_in    = !mem_valid_q || (mem_ready_go && bus.wb_allow_in);
  assign mem_to_wb_valid = mem_valid_q && mem_ready_go;
  assign load_busy       = mem_valid_q && is_ld && !mem_ready_go;
  assign accept          = mem_allow_in && bus.ex_to_mem_valid;
  // First cycle the DRAM word is valid: snapshot it so a WB stall cannot see a later DRAM change.
  assign capture         = mem_valid_q && is_ld && lat_done && !ld_held_q;

  always_comb begin
    mem_valid_d = mem_valid_q;
    lat_cnt_d   = lat_cnt_q;
    ld_held_d   = ld_held_q;
    if (mem_allow_in) mem_valid_d = bus.ex_to_mem_valid;
    if (accept) begin
      lat_cnt_d = '0;
      ld_held_d = 1'b0;
    end else begin
      if (mem_valid_q && is_ld && (lat_cnt_q < LAT)) lat_cnt_d = lat_cnt_q + 3'd1;
      if (capture) ld_held_d = 1'b1;
    end
  end

  // Stage register boundary: control state is reset, data payload is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid_q <= 1'b0;
      lat_cnt_q   <= '0;
      ld_held_q   <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      lat_cnt_q   <= lat_cnt_d;
      ld_held_q   <= ld_held_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept)  mem_regs_q <= bus.ex_to_mem_bus;
    if (capture) ld_word_q  <= bus.dram_rdout;
  end

  assign ld_src = ld_held_q ? ld_word_q : bus.dram_rdout;

  mem_stage_load_ext u_load_ext (
    .op_i         (mem_regs_q.mem_ext_op),
    .offset_i     (mem_regs_q.alu_c[1:0]),
    .word_i       (ld_src),
    .data_o       (ld_data),
    .misaligned_o (misaligned)
  );

  always_comb begin
    rf_wdata = mem_regs_q.alu_c;
    case (mem_regs_q.rf_wsel)
      WB_ALU:  rf_wdata = mem_regs_q.alu_c;
      WB_EXT:  rf_wdata = mem_regs_q.ext;
      WB_PC4:  rf_wdata = mem_regs_q.pc4;
      WB_MEM:  rf_wdata = ld_data;
      default: rf_wdata = mem_regs_q.alu_c;
    endcase
  end

  // A faulting load must not write the register file, and ID must not treat it as a producer.
  assign ld_fault = EXC_EN && is_ld && misaligned;
  assign rf_we    = mem_regs_q.rf_we && !ld_fault;

  assign bus.mem_allow_in    = mem_allow_in;
  assign bus.mem_to_wb_valid = mem_to_wb_valid;
  assign bus.mem_to_wb_bus   = {rf_we, mem_regs_q.wb_reg, rf_wdata};
  assign bus.mem_to_id_bus   = {mem_valid_q, rf_we, mem_regs_q.wb_reg, rf_wdata, load_busy};
  assign bus.mem_exc         = mem_to_wb_valid && ld_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed pipeline scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level model of the stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int LOAD_LAT = 2;
`ifdef MEM_MISALIGN_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_stage_if bus_if ();

  mem_stage #(.LOAD_LAT(LOAD_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model: the instruction in MEM, its DRAM word, and the cycle it entered.
  logic       m_valid;
  ex_to_mem_t m_ins;
  logic [31:0] m_word;
  int         m_entry;
  int         cyc;

  // Stimulus for the next cycle.
  logic       n_rst, n_valid, n_wb;
  ex_to_mem_t n_ins;
  logic [31:0] n_word;

  // Outputs sampled in the last cycle.
  logic       s_allow, s_wbvalid, s_exc, t_acc;
  logic [37:0] s_wbbus;
  logic [39:0] s_idbus;

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    int          r;
    b = 8'(w >> (8 * a));
    h = 16'(w >> (16 * (a / 2)));
    case (op)
      MEM_EXT_LB:  r = int'($signed(b));
      MEM_EXT_LBU: r = int'(b);
      MEM_EXT_LH:  r = int'($signed(h));
      MEM_EXT_LHU: r = int'(h);
      default:     r = int'(w);
    endcase
    return 32'(r);
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] op, input logic [1:0] a);
    if (op == MEM_EXT_LH || op == MEM_EXT_LHU) return a[0];
    if (op == MEM_EXT_LW) return (a != 2'd0);
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_wdata(input ex_to_mem_t ins, input logic [31:0] w);
    case (ins.rf_wsel)
      WB_ALU:  return ins.alu_c;
      WB_EXT:  return ins.ext;
      WB_PC4:  return ins.pc4;
      default: return ref_load(ins.mem_ext_op, ins.alu_c[1:0], w);
    endcase
  endfunction

  function automatic ex_to_mem_t mk(input logic [2:0] op, input logic [1:0] sel,
                                    input logic [4:0] rd, input logic [31:0] alu);
    ex_to_mem_t r;
    r.mem_ext_op = op;
    r.rf_we      = 1'b1;
    r.rf_wsel    = sel;
    r.pc4        = 32'h1000_0004;
    r.ext        = 32'h0ABC_D000;
    r.wb_reg     = rd;
    r.alu_c      = alu;
    return r;
  endfunction

  function automatic ex_to_mem_t rand_ins();
    ex_to_mem_t r;
    r.mem_ext_op = 3'($urandom_range(0, 4));
    r.rf_we      = 1'($urandom());
    r.rf_wsel    = ($urandom() % 2 == 0) ? WB_MEM : 2'($urandom());
    r.pc4        = $urandom();
    r.ext        = $urandom();
    r.wb_reg     = 5'($urandom());
    r.alu_c      = $urandom();
    return r;
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, advance the model.
  task automatic tick();
    int          age;
    logic        ld, ready, fault, we, exp_allow;
    logic [31:0] wd;
    rst                    = n_rst;
    bus_if.ex_to_mem_valid = n_valid;
    bus_if.ex_to_mem_bus   = n_ins;
    bus_if.wb_allow_in     = n_wb;
    age   = cyc - m_entry;
    ld    = (m_ins.rf_wsel == WB_MEM);
    ready = !ld || (age >= LOAD_LAT);
    // DRAM presents the word only in the cycle the latency expires; garbage otherwise.
    bus_if.dram_rdout = (m_valid && ld && age == LOAD_LAT) ? m_word : $urandom();
    exp_allow = !m_valid || (ready && n_wb);
    @(negedge clk);
    s_allow   = bus_if.mem_allow_in;
    s_wbvalid = bus_if.mem_to_wb_valid;
    s_wbbus   = bus_if.mem_to_wb_bus;
    s_idbus   = bus_if.mem_to_id_bus;
    s_exc     = bus_if.mem_exc;
    fault     = EXC_EN && ld && ref_misaligned(m_ins.mem_ext_op, m_ins.alu_c[1:0]);
    check("allow_in", 64'(s_allow), 64'(exp_allow));
    check("wb_valid", 64'(s_wbvalid), 64'(m_valid && ready));
    check("id_valid", 64'(s_idbus[39]), 64'(m_valid));
    check("load_busy", 64'(s_idbus[0]), 64'(m_valid && ld && !ready));
    check("mem_exc", 64'(s_exc), 64'(m_valid && ready && fault));
    if (m_valid) begin
      we = m_ins.rf_we && !fault;
      check("id_we", 64'(s_idbus[38]), 64'(we));
      check("id_rd", 64'(s_idbus[37:33]), 64'(m_ins.wb_reg));
      if (ready) begin
        wd = ref_wdata(m_ins, m_word);
        check("wb_bus", 64'(s_wbbus), 64'({we, m_ins.wb_reg, wd}));
        check("id_wdata", 64'(s_idbus[32:1]), 64'(wd));
      end
    end
    t_acc = !n_rst && exp_allow && n_valid;
    @(posedge clk);
    #1;
    cyc++;
    if (n_rst) m_valid = 1'b0;
    else if (exp_allow) begin
      m_valid = n_valid;
      if (n_valid) begin
        m_ins   = n_ins;
        m_word  = n_word;
        m_entry = cyc;
      end
    end
  endtask

  task automatic issue(input ex_to_mem_t ins, input logic [31:0] word);
    n_ins   = ins;
    n_word  = word;
    n_valid = 1'b1;
    t_acc   = 1'b0;
    for (int i = 0; i < 20 && !t_acc; i++) tick();
    n_valid = 1'b0;
    check("issue_accepted", 64'(t_acc), 64'(1));
  endtask

  task automatic wait_wb(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_wbvalid && n < 20);
    check("wb_offered", 64'(s_wbvalid), 64'(1));
  endtask

  initial begin
    int lat;
    rst                    = 1'b1;
    bus_if.ex_to_mem_valid = 1'b0;
    bus_if.ex_to_mem_bus   = '0;
    bus_if.wb_allow_in     = 1'b1;
    bus_if.dram_rdout      = '0;
    m_valid = 1'b0;
    m_ins   = '0;
    m_word  = '0;
    m_entry = 0;
    cyc     = 0;
    n_rst   = 1'b1;
    n_valid = 1'b0;
    n_wb    = 1'b1;
    n_ins   = '0;
    n_word  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset values
    tick();
    check("rst_allow", 64'(s_allow), 64'(1));
    check("rst_wb_valid", 64'(s_wbvalid), 64'(0));
    check("rst_busy", 64'(s_idbus[0]), 64'(0));
    check("rst_exc", 64'(s_exc), 64'(0));
    n_rst = 1'b0;
    tick();

    // ALU result passes in one cycle, valid for one cycle
    issue(mk(MEM_EXT_LW, WB_ALU, 5'd7, 32'h0000_0015), 32'h0);
    wait_wb(lat);
    check("add_lat", 64'(lat), 64'(1));
    check("add_bus", 64'(s_wbbus), 64'({1'b1, 5'd7, 32'h0000_0015}));
    tick();
    check("add_one_cycle", 64'(s_wbvalid), 64'(0));

    // LB at offset 3
    issue(mk(MEM_EXT_LB, WB_MEM, 5'd8, 32'h0000_0103), 32'h80FF_1234);
    tick();
    check("lb_busy0", 64'(s_idbus[0]), 64'(1));
    tick();
    check("lb_busy1", 64'(s_idbus[0]), 64'(1));
    tick();
    check("lb_valid", 64'(s_wbvalid), 64'(1));
    check("lb_data", 64'(s_wbbus[31:0]), 64'(32'hFFFF_FF80));
    tick();

    // LHU then LH back to back; LH enters the cycle LHU leaves
    issue(mk(MEM_EXT_LHU, WB_MEM, 5'd4, 32'h0000_0202), 32'h8001_0000);
    n_ins = mk(MEM_EXT_LH, WB_MEM, 5'd5, 32'h0000_0302);
    n_word = 32'h8001_0000;
    n_valid = 1'b1;
    t_acc = 1'b0;
    lat = 0;
    while (!t_acc && lat < 20) begin
      tick();
      lat++;
    end
    n_valid = 1'b0;
    check("b2b_accept_lat", 64'(lat), 64'(LOAD_LAT + 1));
    check("b2b_lhu_valid", 64'(s_wbvalid), 64'(1));
    check("lhu_data", 64'(s_wbbus[31:0]), 64'(32'h0000_8001));
    wait_wb(lat);
    check("b2b_lh_lat", 64'(lat), 64'(LOAD_LAT + 1));
    check("lh_data", 64'(s_wbbus[31:0]), 64'(32'hFFFF_8001));
    tick();

    // WB stall on a completed load while DRAM output changes
    n_wb = 1'b0;
    issue(mk(MEM_EXT_LW, WB_MEM, 5'd9, 32'h0000_0200), 32'hCAFE_BABE);
    wait_wb(lat);
    check("stall_lat", 64'(lat), 64'(LOAD_LAT + 1));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_allow", 64'(s_allow), 64'(0));
      check("stall_bus", 64'(s_wbbus), 64'({1'b1, 5'd9, 32'hCAFE_BABE}));
    end
    n_wb = 1'b1;
    tick();
    check("stall_release", 64'(s_wbvalid), 64'(1));
    check("stall_release_data", 64'(s_wbbus[31:0]), 64'(32'hCAFE_BABE));
    tick();
    check("stall_gone", 64'(s_wbvalid), 64'(0));

    // Misaligned LW
    issue(mk(MEM_EXT_LW, WB_MEM, 5'd3, 32'h0000_0102), 32'h1122_3344);
    wait_wb(lat);
    check("mis_exc", 64'(s_exc), 64'(EXC_EN));
    check("mis_we", 64'(s_wbbus[37]), 64'(!EXC_EN));
    check("mis_data", 64'(s_wbbus[31:0]), 64'(32'h1122_3344));
    tick();

    // Reset while a load is one cycle into its latency
    issue(mk(MEM_EXT_LW, WB_MEM, 5'd6, 32'h0000_0300), 32'h1234_5678);
    tick();
    n_rst = 1'b1;
    tick();
    check("rstmid_busy", 64'(s_idbus[0]), 64'(1));
    n_rst = 1'b0;
    for (int i = 0; i < LOAD_LAT + 3; i++) begin
      tick();
      check("rstmid_no_wb", 64'(s_wbvalid), 64'(0));
      check("rstmid_idle", 64'(s_idbus[39]), 64'(0));
    end

    // Randomized traffic with occasional resets and WB stalls
    for (int c = 0; c < 800; c++) begin
      n_rst   = ($urandom_range(0, 99) == 0);
      n_valid = ($urandom() % 4) != 0;
      n_wb    = ($urandom() % 4) != 0;
      n_ins   = rand_ins();
      n_word  = $urandom();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
